serial_sub_ctrl: RTL and testbench
==================================

// Module: serial_sub_ctrl
// PURPOSE
//  Sequencer that time-shares one NAND-built full subtractor across a WIDTH-bit operand pair.
//  Bits are processed LSB-first, one per clock, with a registered borrow chain.
//  Valid/ready handshake on input and output.
//  Sits between an operand source and a result consumer; replaces a WIDTH-wide ripple subtractor.
// PARAMETERS
//  WIDTH   8   operand/result width in bits (>=1)
//  CNT_W   $clog2(WIDTH)+1   bit-counter width (derived, not overridden)
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      synchronous reset, active-high
//  in_valid   in   1      operand pair a/b/bin valid
//  in_ready   out  1      controller can accept operands (IDLE only)
//  a          in   WIDTH  minuend
//  b          in   WIDTH  subtrahend
//  bin        in   1      borrow-in for bit 0
//  out_valid  out  1      diff/bout valid; held until consumed
//  out_ready  in   1      consumer accepts result
//  diff       out  WIDTH  (a - b - bin) mod 2^WIDTH
//  bout       out  1      final borrow: 1 iff a < b + bin (unsigned)
//  busy       out  1      1 in RUN or DONE
// BEHAVIOUR
//  - Reset (rst=1 at posedge): state=IDLE; in_ready=1 on the following cycle; out_valid=0, diff=0, bout=0, busy=0.
//    Shift regs, borrow reg and counter are cleared.
//    rst overrides all other inputs.
//  - States: IDLE -> RUN -> DONE -> IDLE. Encoding: IDLE=2'd0, RUN=2'd1, DONE=2'd2; 2'd3 -> IDLE.
//  - IDLE: in_ready=1. On in_valid: latch a, b into shift regs, borrow_reg<=bin, cnt<=0; go RUN.
//  - RUN: in_ready=0. Each cycle the FS sees a_sh[0], b_sh[0], borrow_reg.
//    d bit shifts into the MSB of the result reg; borrow_reg<=fs_bout; a_sh, b_sh shift right; cnt++.
//    When cnt==WIDTH-1 is processed, go DONE.
//  - DONE: out_valid=1, diff=result reg, bout=borrow_reg, all stable.
//    On out_ready go IDLE: out_valid drops next cycle and diff/bout keep their last values.
//    Without out_ready, DONE holds indefinitely.
//  - Latency: acceptance edge E0; out_valid is high after edge E_WIDTH (WIDTH clocks).
//    Best-case throughput is one op per WIDTH+2 clocks.
//  - in_valid while in_ready=0 is ignored; the source must hold its data until accepted.
//  - A new op cannot be accepted in the same cycle as result consumption.
//  - out_ready while out_valid=0 has no effect.
//  - WIDTH=1: exactly one RUN cycle.
//  - rst during RUN/DONE aborts the op and discards the partial result; no out_valid pulse.
//  - Underflow is not an error: wrap mod 2^WIDTH and flag it via bout.
// STRUCTURE
//  - Shared package/include serial_sub_pkg: state localparams (ST_IDLE/ST_RUN/ST_DONE), state width 2.
//  - Sub-module fs_nand (a, b, bin, d, bout): full subtractor built from two hs_nand instances.
//    Borrow combine is done with NAND only. Purely combinational, one instance in this block.
//  - This block: FSM, counter, two operand shift regs, result shift reg, borrow reg.
// TESTING (WIDTH=8 unless stated)
//  1. a=0x05, b=0x03, bin=0 -> diff=0x02, bout=0; out_valid rises exactly 8 clocks after acceptance.
//  2. a=0x03, b=0x05, bin=0 -> diff=0xFE, bout=1.
//     Also a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1.
//  3. Backpressure: out_ready=0 for 5 cycles in DONE -> diff/bout/out_valid stable.
//     in_valid with new data ignored (in_ready=0); out_ready=1 -> IDLE next cycle.
//  4. rst pulsed at RUN cycle 3 -> out_valid never asserts; next op a=0xA0, b=0x0A -> diff=0x96, bout=0.
//  5. Back-to-back: in_valid held high, out_ready=1 -> ops accepted every 10 clocks, all results correct.
//  6. WIDTH=1 build: all 8 (a,b,bin) combinations -> diff=a^b^bin, bout=(~a&b)|(~(a^b)&bin), latency 1.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor controller.
package serial_sub_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/fs_nand.sv
// Combinational full subtractor from two NAND half subtractors; borrows merged by NAND-OR.
module fs_nand (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic d0;
  logic b0;
  logic b1;

  hs_nand u_hs0 (
    .a    (a),
    .b    (b),
    .d    (d0),
    .bout (b0)
  );

  hs_nand u_hs1 (
    .a    (d0),
    .b    (bin),
    .d    (d),
    .bout (b1)
  );

  // b0 | b1 expressed as NAND of the inverted borrows.
  assign bout = ~(~(b0 & b0) & ~(b1 & b1));

endmodule

// File: rtl/hs_nand.sv
// Half subtractor (d = a ^ b, bout = ~a & b) built only from 2-input NAND gates.
module hs_nand (
  input  logic a,
  input  logic b,
  output logic d,
  output logic bout
);

  logic n_ab;
  logic n_a;
  logic n_b;
  logic a_n;
  logic t;

  // Classic four-NAND XOR for the difference bit.
  assign n_ab = ~(a & b);
  assign n_a  = ~(a & n_ab);
  assign n_b  = ~(b & n_ab);
  assign d    = ~(n_a & n_b);

  // Borrow ~a & b: invert a with a tied NAND, then NAND-NAND forms the AND.
  assign a_n  = ~(a & a);
  assign t    = ~(a_n & b);
  assign bout = ~(t & t);

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor: one shared NAND full subtractor walks a WIDTH-bit operand
// pair LSB-first, one bit per clock, behind valid/ready handshakes.
module serial_sub_ctrl
  import serial_sub_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             busy
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e           state_q,  state_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [WIDTH-1:0] a_sh_q,   a_sh_d;
  logic [WIDTH-1:0] b_sh_q,   b_sh_d;
  logic [WIDTH-1:0] res_q,    res_d;
  logic             borrow_q, borrow_d;

  logic fs_d;
  logic fs_bout;

  fs_nand u_fs (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .bin  (borrow_q),
    .d    (fs_d),
    .bout (fs_bout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_q    <= '0;
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_q    <= res_d;
      borrow_q <= borrow_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_d    = res_q;
    borrow_d = borrow_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_sh_d   = a;
          b_sh_d   = b;
          borrow_d = bin;
          cnt_d    = '0;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        // Difference bits enter at the MSB so bit 0 ends up in place after WIDTH shifts.
        res_d    = WIDTH'({fs_d, res_q} >> 1);
        borrow_d = fs_bout;
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_RUN) || (state_q == ST_DONE);
  assign diff      = res_q;
  assign bout      = borrow_q;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Scoreboard bench for serial_sub_ctrl: an 8-bit instance for the main scenarios and a 1-bit instance.
module tb_serial_sub_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       inValid;
  logic       inReady;
  logic [7:0] a;
  logic [7:0] b;
  logic       bin;
  logic       outValid;
  logic       outReady;
  logic [7:0] diff;
  logic       bout;
  logic       busy;

  logic       inValid1;
  logic       inReady1;
  logic [0:0] a1;
  logic [0:0] b1;
  logic       bin1;
  logic       outValid1;
  logic       outReady1;
  logic [0:0] diff1;
  logic       bout1;
  logic       busy1;

  logic [8:0] expQ[$];
  logic [1:0] expQ1[$];

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  serial_sub_ctrl #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (inValid),
    .in_ready  (inReady),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (outValid),
    .out_ready (outReady),
    .diff      (diff),
    .bout      (bout),
    .busy      (busy)
  );

  serial_sub_ctrl #(.WIDTH(1)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (inValid1),
    .in_ready  (inReady1),
    .a         (a1),
    .b         (b1),
    .bin       (bin1),
    .out_valid (outValid1),
    .out_ready (outReady1),
    .diff      (diff1),
    .bout      (bout1),
    .busy      (busy1)
  );

  // Reference: 9-bit unsigned subtraction, bit 8 is the final borrow.
  function automatic logic [8:0] model(input logic [7:0] x, input logic [7:0] y, input logic c);
    logic [8:0] r;
    r = {1'b0, x} - {1'b0, y} - {8'd0, c};
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic popExp(output logic [8:0] e);
    if (expQ.size() == 0) e = 'x;
    else e = expQ.pop_front();
  endtask

  task automatic acceptOp(input logic [7:0] x, input logic [7:0] y, input logic c, output logic ok);
    ok = 1'b0;
    a = x;
    b = y;
    bin = c;
    inValid = 1'b1;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (inReady) begin
        expQ.push_back(model(x, y, c));
        ok = 1'b1;
      end
      step();
    end
    inValid = 1'b0;
  endtask

  task automatic waitResult(input int maxCycles, output int cycles);
    cycles = 0;
    while (cycles < maxCycles && !outValid) begin
      step();
      cycles++;
    end
  endtask

  task automatic consume();
    outReady = 1'b1;
    step();
    outReady = 1'b0;
  endtask

  task automatic test_reset();
    inValid = 1'b1;
    a = 8'hFF;
    b = 8'h01;
    rst = 1'b1;
    step();
    rst = 1'b0;
    inValid = 1'b0;
    compared++; if (inReady !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_in_ready: got %b expected 1", inReady); end
    compared++; if (outValid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_out_valid: got %b expected 0", outValid); end
    compared++; if (diff !== 8'h00) begin mismatched++; $display("[TB] FAIL reset_diff: got %h expected 00", diff); end
    compared++; if (bout !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_bout: got %b expected 0", bout); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    compared++; if (inReady1 !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_in_ready_w1: got %b expected 1", inReady1); end
  endtask

  task automatic test_basic();
    logic ok;
    int lat;
    logic [8:0] e;
    acceptOp(8'h05, 8'h03, 1'b0, ok);
    compared++; if (ok !== 1'b1) begin mismatched++; $display("[TB] FAIL basic_accept: got %b expected 1", ok); end
    waitResult(20, lat);
    compared++; if (lat !== 8) begin mismatched++; $display("[TB] FAIL basic_latency: got %0d expected 8", lat); end
    compared++; if (busy !== 1'b1) begin mismatched++; $display("[TB] FAIL basic_busy: got %b expected 1", busy); end
    popExp(e);
    compared++; if (diff !== e[7:0]) begin mismatched++; $display("[TB] FAIL basic_diff: got %h expected %h", diff, e[7:0]); end
    compared++; if (bout !== e[8]) begin mismatched++; $display("[TB] FAIL basic_bout: got %b expected %b", bout, e[8]); end
    consume();
    compared++; if (outValid !== 1'b0) begin mismatched++; $display("[TB] FAIL basic_out_valid_drop: got %b expected 0", outValid); end
    compared++; if (diff !== e[7:0]) begin mismatched++; $display("[TB] FAIL basic_diff_hold: got %h expected %h", diff, e[7:0]); end
    compared++; if (inReady !== 1'b1) begin mismatched++; $display("[TB] FAIL basic_back_idle: got %b expected 1", inReady); end
  endtask

  task automatic test_underflow();
    logic ok;
    int lat;
    logic [8:0] e;
    logic [7:0] xs[2] = '{8'h03, 8'h00};
    logic [7:0] ys[2] = '{8'h05, 8'h00};
    logic       cs[2] = '{1'b0, 1'b1};
    for (int k = 0; k < 2; k++) begin
      acceptOp(xs[k], ys[k], cs[k], ok);
      waitResult(20, lat);
      compared++; if (outValid !== 1'b1) begin mismatched++; $display("[TB] FAIL underflow_valid%0d: got %b expected 1", k, outValid); end
      popExp(e);
      compared++; if (diff !== e[7:0]) begin mismatched++; $display("[TB] FAIL underflow_diff%0d: got %h expected %h", k, diff, e[7:0]); end
      compared++; if (bout !== e[8]) begin mismatched++; $display("[TB] FAIL underflow_bout%0d: got %b expected %b", k, bout, e[8]); end
      consume();
    end
  endtask

  task automatic test_backpressure();
    logic ok;
    int lat;
    logic [8:0] e;
    acceptOp(8'h5A, 8'h3C, 1'b1, ok);
    waitResult(20, lat);
    popExp(e);
    inValid = 1'b1;
    a = 8'h11;
    b = 8'h22;
    bin = 1'b0;
    for (int k = 0; k < 5; k++) begin
      compared++; if (outValid !== 1'b1) begin mismatched++; $display("[TB] FAIL bp_valid%0d: got %b expected 1", k, outValid); end
      compared++; if (diff !== e[7:0]) begin mismatched++; $display("[TB] FAIL bp_diff%0d: got %h expected %h", k, diff, e[7:0]); end
      compared++; if (bout !== e[8]) begin mismatched++; $display("[TB] FAIL bp_bout%0d: got %b expected %b", k, bout, e[8]); end
      compared++; if (inReady !== 1'b0) begin mismatched++; $display("[TB] FAIL bp_in_ready%0d: got %b expected 0", k, inReady); end
      step();
    end
    consume();
    compared++; if (outValid !== 1'b0) begin mismatched++; $display("[TB] FAIL bp_release_valid: got %b expected 0", outValid); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL bp_no_same_cycle_accept: got busy %b expected 0", busy); end
    compared++; if (inReady !== 1'b1) begin mismatched++; $display("[TB] FAIL bp_idle: got %b expected 1", inReady); end
    inValid = 1'b0;
  endtask

  task automatic test_abort();
    logic ok;
    int lat;
    logic [8:0] e;
    logic sawValid;
    acceptOp(8'hFF, 8'h01, 1'b0, ok);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    popExp(e);
    compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL abort_busy: got %b expected 0", busy); end
    compared++; if (diff !== 8'h00) begin mismatched++; $display("[TB] FAIL abort_diff_cleared: got %h expected 00", diff); end
    sawValid = 1'b0;
    for (int k = 0; k < 15; k++) begin
      sawValid |= outValid;
      step();
    end
    compared++; if (sawValid !== 1'b0) begin mismatched++; $display("[TB] FAIL abort_no_valid: got %b expected 0", sawValid); end
    acceptOp(8'hA0, 8'h0A, 1'b0, ok);
    waitResult(20, lat);
    compared++; if (lat !== 8) begin mismatched++; $display("[TB] FAIL abort_next_latency: got %0d expected 8", lat); end
    popExp(e);
    compared++; if (diff !== e[7:0]) begin mismatched++; $display("[TB] FAIL abort_next_diff: got %h expected %h", diff, e[7:0]); end
    compared++; if (bout !== e[8]) begin mismatched++; $display("[TB] FAIL abort_next_bout: got %b expected %b", bout, e[8]); end
    consume();
  endtask

  task automatic test_back_to_back();
    logic [7:0] opA[4] = '{8'h12, 8'hFF, 8'h80, 8'h00};
    logic [7:0] opB[4] = '{8'h34, 8'hFF, 8'h7F, 8'h00};
    logic       opC[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    int issued = 0;
    int got = 0;
    int cyc = 0;
    int lastAcc = 0;
    logic acceptNow;
    logic [8:0] e;
    opA[3] = 8'($urandom);
    opB[3] = 8'($urandom);
    opC[3] = 1'($urandom);
    outReady = 1'b1;
    a = opA[0];
    b = opB[0];
    bin = opC[0];
    inValid = 1'b1;
    while (got < 4 && cyc < 200) begin
      if (outValid) begin
        popExp(e);
        compared++; if (diff !== e[7:0]) begin mismatched++; $display("[TB] FAIL b2b_diff%0d: got %h expected %h", got, diff, e[7:0]); end
        compared++; if (bout !== e[8]) begin mismatched++; $display("[TB] FAIL b2b_bout%0d: got %b expected %b", got, bout, e[8]); end
        got++;
      end
      acceptNow = inReady && (issued < 4);
      if (acceptNow) begin
        expQ.push_back(model(opA[issued], opB[issued], opC[issued]));
        if (issued > 0) begin
          compared++; if (cyc - lastAcc !== 10) begin mismatched++; $display("[TB] FAIL b2b_interval%0d: got %0d expected 10", issued, cyc - lastAcc); end
        end
        lastAcc = cyc;
        issued++;
      end
      step();
      cyc++;
      if (acceptNow) begin
        if (issued < 4) begin
          a = opA[issued];
          b = opB[issued];
          bin = opC[issued];
        end else begin
          inValid = 1'b0;
        end
      end
    end
    compared++; if (got !== 4) begin mismatched++; $display("[TB] FAIL b2b_results: got %0d expected 4", got); end
    outReady = 1'b0;
    inValid = 1'b0;
  endtask

  task automatic test_width1();
    logic ok;
    int lat;
    logic [2:0] v;
    logic x, y, c;
    logic [1:0] e;
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      x = v[2];
      y = v[1];
      c = v[0];
      a1 = x;
      b1 = y;
      bin1 = c;
      inValid1 = 1'b1;
      ok = 1'b0;
      for (int j = 0; j < 10 && !ok; j++) begin
        if (inReady1) begin
          expQ1.push_back({(~x & y) | (~(x ^ y) & c), x ^ y ^ c});
          ok = 1'b1;
        end
        step();
      end
      inValid1 = 1'b0;
      lat = 0;
      while (lat < 10 && !outValid1) begin
        step();
        lat++;
      end
      compared++; if (lat !== 1) begin mismatched++; $display("[TB] FAIL w1_latency%0d: got %0d expected 1", i, lat); end
      compared++; if (busy1 !== 1'b1) begin mismatched++; $display("[TB] FAIL w1_busy%0d: got %b expected 1", i, busy1); end
      if (expQ1.size() == 0) e = 'x;
      else e = expQ1.pop_front();
      compared++; if (diff1 !== e[0]) begin mismatched++; $display("[TB] FAIL w1_diff%0d: got %b expected %b", i, diff1, e[0]); end
      compared++; if (bout1 !== e[1]) begin mismatched++; $display("[TB] FAIL w1_bout%0d: got %b expected %b", i, bout1, e[1]); end
      outReady1 = 1'b1;
      step();
      outReady1 = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b0;
    inValid = 1'b0;
    a = '0;
    b = '0;
    bin = 1'b0;
    outReady = 1'b0;
    inValid1 = 1'b0;
    a1 = '0;
    b1 = '0;
    bin1 = 1'b0;
    outReady1 = 1'b0;
    #2;
    test_reset();
    test_basic();
    test_underflow();
    test_backpressure();
    test_abort();
    test_back_to_back();
    test_width1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
